// File: rtl/ks_adder_if.sv
// Stream bundle for ks_adder_pipe: operand beat in, result beat out, each with valid/ready.
// The master modport drives operands and accepts results; the slave modport is the adder side.
interface ks_adder_if #(
  parameter int WIDTH = 16,
  parameter int TAG_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             op;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, a, b, cin, op, in_tag, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, out_tag
  );

  modport slave (
    input  in_valid, a, b, cin, op, in_tag, out_ready,
    output in_ready, out_valid, sum, cout, ovf, out_tag
  );
endinterface

// File: rtl/ks_adder_pipe.sv
// Pipelined Kogge-Stone adder/subtractor, a register stage after every STAGE_LVLS prefix levels.
// Optional feature macro: KS_ADDER_OVF_EN builds the signed-overflow path; otherwise ovf is tied to 0.
module ks_adder_pipe #(
  parameter int WIDTH      = 16,
  parameter int STAGE_LVLS = 1,
  parameter int TAG_W      = 4
) (
  input  logic      clk,
  input  logic      rst_n,
  ks_adder_if.slave bus
);
  localparam int L = $clog2(WIDTH);
  localparam int N = (L + STAGE_LVLS - 1) / STAGE_LVLS;

  // Stage valids: bits 0..N-1 are prefix stages, bit N is the output stage.
  logic [N:0] vld_q;
  logic [N:0] vld_d;
  logic [N:0] load;
  logic [N:0] ready;
  logic       drain;

  always_comb begin
    ready    = '0;
    load     = '0;
    vld_d    = vld_q;
    drain    = vld_q[N] & bus.out_ready;
    ready[N] = ~vld_q[N] | drain;
    load[N]  = vld_q[N-1] & ready[N];
    for (int k = N - 1; k >= 1; k--) begin
      ready[k] = ~vld_q[k] | load[k+1];
      load[k]  = vld_q[k-1] & ready[k];
    end
    ready[0] = ~vld_q[0] | load[1];
    load[0]  = bus.in_valid & ready[0];
    vld_d[N] = load[N] | (vld_q[N] & ~drain);
    for (int k = 0; k < N; k++) begin
      vld_d[k] = load[k] | (vld_q[k] & ~load[k+1]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
    end else begin
      vld_q <= vld_d;
    end
  end

  assign bus.in_ready  = rst_n & ready[0];
  assign bus.out_valid = vld_q[N];

  // Prefix levels. Array index x holds bit position x-1, so index 0 is the fake position -1.
  for (genvar gk = 0; gk < L; gk++) begin : g_lvl
    localparam int SPAN = 1 << gk;
    localparam logic [WIDTH-1:0] LOW_MASK = ~({WIDTH{1'b1}} << SPAN);

    logic [WIDTH-1:0] g_in;
    logic [WIDTH-1:0] p_in;
    logic [WIDTH-1:0] g_out;

    if (gk % STAGE_LVLS == 0) begin : g_from_reg
      assign g_in = g_stage[gk / STAGE_LVLS].pg_g_q;
      assign p_in = g_stage[gk / STAGE_LVLS].pg_p_q;
    end else begin : g_from_lvl
      assign g_in = g_lvl[gk-1].g_out;
      assign p_in = g_lvl[gk-1].g_pn.p_out;
    end

    // Zeros shifted in below SPAN make the low positions pass through unchanged.
    assign g_out = g_in | (p_in & (g_in << SPAN));

    if (gk < L - 1) begin : g_pn
      logic [WIDTH-1:0] p_out;
      assign p_out = p_in & ((p_in << SPAN) | LOW_MASK);
    end
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_stage
    logic [WIDTH-1:0] pg_g_d;
    logic [WIDTH-1:0] pg_p_d;
    logic [WIDTH-1:0] pbit_d;
    logic             gmsb_d;
    logic [TAG_W-1:0] tag_d;
    logic [WIDTH-1:0] pg_g_q;
    logic [WIDTH-1:0] pg_p_q;
    logic [WIDTH-1:0] pbit_q;
    logic             gmsb_q;
    logic [TAG_W-1:0] tag_q;

    if (gi == 0) begin : g_pre
      logic [WIDTH-1:0] b_eff;
      logic [WIDTH-1:0] pre_p;
      logic [WIDTH-1:0] pre_g;

      assign b_eff  = bus.op ? ~bus.b : bus.b;
      assign pre_p  = bus.a ^ b_eff;
      assign pre_g  = bus.a & b_eff;
      // Subtract forces the +1 of two's complement through the fake position.
      assign pg_g_d = {pre_g[WIDTH-2:0], bus.op | bus.cin};
      assign pg_p_d = {pre_p[WIDTH-2:0], 1'b0};
      assign pbit_d = pre_p;
      assign gmsb_d = pre_g[WIDTH-1];
      assign tag_d  = bus.in_tag;
    end else begin : g_mid
      assign pg_g_d = g_lvl[gi*STAGE_LVLS-1].g_out;
      assign pg_p_d = g_lvl[gi*STAGE_LVLS-1].g_pn.p_out;
      assign pbit_d = g_stage[gi-1].pbit_q;
      assign gmsb_d = g_stage[gi-1].gmsb_q;
      assign tag_d  = g_stage[gi-1].tag_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        pg_g_q <= '0;
        pg_p_q <= '0;
        pbit_q <= '0;
        gmsb_q <= 1'b0;
        tag_q  <= '0;
      end else if (load[gi]) begin
        pg_g_q <= pg_g_d;
        pg_p_q <= pg_p_d;
        pbit_q <= pbit_d;
        gmsb_q <= gmsb_d;
        tag_q  <= tag_d;
      end
    end
  end

  // Post-node and grey cell: carry[i] is the carry into bit i.
  logic [WIDTH-1:0] carry;
  logic [WIDTH-1:0] sum_d;
  logic [WIDTH-1:0] sum_q;
  logic             cout_d;
  logic             cout_q;
  logic [TAG_W-1:0] otag_q;

  assign carry  = g_lvl[L-1].g_out;
  assign sum_d  = g_stage[N-1].pbit_q ^ carry;
  assign cout_d = g_stage[N-1].gmsb_q | (g_stage[N-1].pbit_q[WIDTH-1] & carry[WIDTH-1]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q  <= '0;
      cout_q <= 1'b0;
      otag_q <= '0;
    end else if (load[N]) begin
      sum_q  <= sum_d;
      cout_q <= cout_d;
      otag_q <= g_stage[N-1].tag_q;
    end
  end

  assign bus.sum     = sum_q;
  assign bus.cout    = cout_q;
  assign bus.out_tag = otag_q;

`ifdef KS_ADDER_OVF_EN
  logic ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (load[N]) begin
      ovf_q <= cout_d ^ carry[WIDTH-1];
    end
  end

  assign bus.ovf = ovf_q;
`else
  assign bus.ovf = 1'b0;
`endif

endmodule
